// File: rtl/ov7670_cfg_pkg.sv
// ov7670_cfg_pkg: shared types and constants for the OV7670 register-list sequencer.
//   cfg_state_e   sequencer states
//   CFG_END       end-of-list marker entry
//   CFG_DELAY     delay marker entry
//   DEFAULT_ID    SCCB write address of the OV7670
package ov7670_cfg_pkg;

    localparam int unsigned ENTRY_W = 16;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned CNT_W   = 20;

    localparam logic [7:0]         DEFAULT_ID = 8'h42;
    localparam logic [ENTRY_W-1:0] CFG_END    = 16'hFFFF;
    localparam logic [ENTRY_W-1:0] CFG_DELAY  = 16'hFFF0;

    typedef enum logic [2:0] {
        PWR_WAIT,
        FETCH,
        ISSUE,
        HOLD,
        DELAY,
        DONE
    } cfg_state_e;

endpackage

// File: rtl/ov7670_reg_rom.sv
// ov7670_reg_rom: OV7670 initialisation table, {register address, value} per entry.
//   clk   clock
//   addr  entry index
//   data  entry at addr, registered (1-cycle read latency)
module ov7670_reg_rom
    import ov7670_cfg_pkg::*;
(
    input  logic               clk,
    input  logic [IDX_W-1:0]   addr,
    output logic [ENTRY_W-1:0] data
);

    logic [ENTRY_W-1:0] entry_c;

    // Table contents; unlisted indices read as end-of-list
    always_comb begin
        entry_c = CFG_END;
        case (addr)
            8'd0:    entry_c = 16'h1280; // COM7: soft reset
            8'd1:    entry_c = CFG_DELAY;
            8'd2:    entry_c = 16'h1204; // COM7: RGB output
            8'd3:    entry_c = 16'h1100; // CLKRC: no prescale
            8'd4:    entry_c = 16'h0C00; // COM3
            8'd5:    entry_c = 16'h3E00; // COM14
            8'd6:    entry_c = 16'h8C00; // RGB444 off
            8'd7:    entry_c = 16'h0400; // COM1
            8'd8:    entry_c = 16'h4010; // COM15: RGB565
            8'd9:    entry_c = 16'h3A04; // TSLB
            8'd10:   entry_c = 16'h1438; // COM9: AGC ceiling
            8'd11:   entry_c = 16'h4FB3; // MTX1
            8'd12:   entry_c = 16'h50B3; // MTX2
            8'd13:   entry_c = 16'h5100; // MTX3
            8'd14:   entry_c = 16'h523D; // MTX4
            8'd15:   entry_c = 16'h53A7; // MTX5
            8'd16:   entry_c = 16'h54E4; // MTX6
            8'd17:   entry_c = 16'h589E; // MTXS
            8'd18:   entry_c = 16'h3DC0; // COM13: gamma, UV saturation
            default: entry_c = CFG_END;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= entry_c;
    end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer: walks the OV7670 register ROM and feeds each pair to the SCCB sender.
//   clk          clock
//   clr          synchronous active-high reset
//   resend       restart the table from index 0
//   taken        sender accepted the current request
//   send         request to the sender
//   id           SCCB write address (constant ID)
//   rega, value  register address / value of the current entry
//   config_done  end of list reached
// Build option: OV7670_POWERUP_DELAY_EN adds a POWERUP_CYCLES wait after reset.
module ov7670_cfg_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter logic [7:0]  ID             = DEFAULT_ID,
    parameter int unsigned HOLD_CYCLES    = 256,
    parameter int unsigned DELAY_CYCLES   = 500000,
    parameter int unsigned POWERUP_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       resend,
    input  logic       taken,
    output logic       send,
    output logic [7:0] id,
    output logic [7:0] rega,
    output logic [7:0] value,
    output logic       config_done
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = {IDX_W{1'b1}};

`ifdef OV7670_POWERUP_DELAY_EN
    localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(POWERUP_CYCLES - 1);
    localparam cfg_state_e       RESET_STATE = PWR_WAIT;
`else
    localparam cfg_state_e       RESET_STATE = FETCH;
`endif

    // Every wait must fit the 20-bit counter and be at least one cycle
    if (HOLD_CYCLES == 0 || DELAY_CYCLES == 0 || POWERUP_CYCLES == 0 ||
        HOLD_CYCLES > (32'd1 << CNT_W) || DELAY_CYCLES > (32'd1 << CNT_W) ||
        POWERUP_CYCLES > (32'd1 << CNT_W)) begin : g_bad_cycles
        $error("ov7670_cfg_sequencer: cycle parameter out of range");
    end

    cfg_state_e         state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               send_d, done_d;
    logic [7:0]         rega_d, value_d;
    logic [ENTRY_W-1:0] entry;

    assign id = ID;

    ov7670_reg_rom u_rom (
        .clk  (clk),
        .addr (idx),
        .data (entry)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= RESET_STATE;
            idx         <= '0;
            cnt         <= '0;
            send        <= 1'b0;
            rega        <= '0;
            value       <= '0;
            config_done <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            send        <= send_d;
            rega        <= rega_d;
            value       <= value_d;
            config_done <= done_d;
        end
    end

    // Next state / outputs; FETCH spends cnt==0 waiting for the ROM, decodes at cnt==1
    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt + CNT_W'(1);
        send_d  = send;
        rega_d  = rega;
        value_d = value;
        done_d  = config_done;

        if (resend) begin
            state_d = FETCH;
            idx_d   = '0;
            cnt_d   = '0;
            send_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state)
`ifdef OV7670_POWERUP_DELAY_EN
                PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        state_d = FETCH;
                        cnt_d   = '0;
                    end
                end
`endif
                FETCH: begin
                    if (cnt != '0) begin
                        cnt_d = '0;
                        // Last index doubles as end of list so the index never wraps
                        if (entry == CFG_END || idx == IDX_LAST) begin
                            state_d = DONE;
                            send_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (entry == CFG_DELAY) begin
                            state_d = DELAY;
                            send_d  = 1'b0;
                        end else begin
                            state_d = ISSUE;
                            send_d  = 1'b1;
                            rega_d  = entry[15:8];
                            value_d = entry[7:0];
                        end
                    end
                end
                ISSUE: begin
                    cnt_d = '0;
                    if (taken) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state_d = FETCH;
                        idx_d   = idx + IDX_W'(1);
                        cnt_d   = '0;
                    end
                end
                DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        state_d = FETCH;
                        idx_d   = idx + IDX_W'(1);
                        cnt_d   = '0;
                    end
                end
                DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = RESET_STATE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// tb_ov7670_cfg_sequencer: directed bench for the OV7670 register-list sequencer.
module tb_ov7670_cfg_sequencer;

    localparam int unsigned HOLD = 256;
    localparam int unsigned DLY  = 50;
    localparam int unsigned PWR  = 100;
`ifdef OV7670_POWERUP_DELAY_EN
    localparam int unsigned FIRST_SEND = PWR + 2;
`else
    localparam int unsigned FIRST_SEND = 2;
`endif
    localparam int unsigned N_ISSUED = 18;
    localparam logic [15:0] EXP_TAB [N_ISSUED] = '{
        16'h1280, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h8C00,
        16'h0400, 16'h4010, 16'h3A04, 16'h1438, 16'h4FB3, 16'h50B3,
        16'h5100, 16'h523D, 16'h53A7, 16'h54E4, 16'h589E, 16'h3DC0
    };

    logic       clk, clr, resend, taken;
    logic       send, config_done;
    logic [7:0] id, rega, value;

    int n_cmp, n_err, cycles;

    ov7670_cfg_sequencer #(
        .ID             (8'h42),
        .HOLD_CYCLES    (HOLD),
        .DELAY_CYCLES   (DLY),
        .POWERUP_CYCLES (PWR)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .resend      (resend),
        .taken       (taken),
        .send        (send),
        .id          (id),
        .rega        (rega),
        .value       (value),
        .config_done (config_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cycles++;
    endtask

    // Sender model: accept entries until the given register address is presented
    task automatic serve_until(input logic [7:0] target, output bit ok);
        int start;
        start = cycles;
        while (!(send === 1'b1 && rega === target) && (cycles - start) < 20000) begin
            if (send === 1'b1) begin
                taken = 1'b1; tick(); taken = 1'b0;
                repeat (HOLD + 2) tick();
            end else begin
                tick();
            end
        end
        ok = (send === 1'b1 && rega === target);
    endtask

    task automatic test_reset();
        int k;
        clr = 1'b1;
        repeat (3) tick();
        n_cmp++; if (send !== 1'b0)        begin n_err++; $display("FAIL reset_send: got %b want 0", send); end
        n_cmp++; if (rega !== 8'h00)       begin n_err++; $display("FAIL reset_rega: got %h want 00", rega); end
        n_cmp++; if (value !== 8'h00)      begin n_err++; $display("FAIL reset_value: got %h want 00", value); end
        n_cmp++; if (id !== 8'h42)         begin n_err++; $display("FAIL reset_id: got %h want 42", id); end
        n_cmp++; if (config_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", config_done); end
        clr = 1'b0;
        k = 0;
        while (send !== 1'b1 && k < int'(PWR + 50)) begin tick(); k++; end
        n_cmp++; if (k != int'(FIRST_SEND)) begin n_err++; $display("FAIL first_send_latency: got %0d want %0d", k, FIRST_SEND); end
        n_cmp++; if (rega !== 8'h12)  begin n_err++; $display("FAIL first_rega: got %h want 12", rega); end
        n_cmp++; if (value !== 8'h80) begin n_err++; $display("FAIL first_value: got %h want 80", value); end
        n_cmp++; if (id !== 8'h42)    begin n_err++; $display("FAIL first_id: got %h want 42", id); end
    endtask

    task automatic test_hold_delay();
        int bad, k;
        repeat (3) tick();
        n_cmp++; if (send !== 1'b1 || rega !== 8'h12) begin n_err++; $display("FAIL issue_wait: send %b rega %h want 1/12", send, rega); end
        taken = 1'b1; tick(); taken = 1'b0;
        bad = 0;
        for (int i = 0; i < int'(HOLD + 2); i++) begin
            if (send !== 1'b1 || rega !== 8'h12 || value !== 8'h80) bad++;
            tick();
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad); end
        n_cmp++; if (send !== 1'b0) begin n_err++; $display("FAIL delay_send: got %b want 0", send); end
        // Spurious taken inside the delay must not shorten or skip anything
        k = 0;
        while (send !== 1'b1 && k < int'(DLY + 50)) begin
            taken = (k == 5);
            tick(); k++;
        end
        taken = 1'b0;
        n_cmp++; if (k != int'(DLY + 2)) begin n_err++; $display("FAIL delay_length: got %0d want %0d", k, DLY + 2); end
        n_cmp++; if (rega !== 8'h12 || value !== 8'h04) begin n_err++; $display("FAIL entry2: got %h%h want 1204", rega, value); end
    endtask

    task automatic test_full_table();
        logic [15:0] got [32];
        int n, start;
        resend = 1'b1; tick(); resend = 1'b0;
        n = 0; start = cycles;
        while (config_done !== 1'b1 && (cycles - start) < 20000 && n < 32) begin
            if (send === 1'b1) begin
                repeat (10) tick();
                got[n] = {rega, value};
                n++;
                taken = 1'b1; tick(); taken = 1'b0;
                repeat (HOLD + 2) tick();
            end else begin
                tick();
            end
        end
        n_cmp++; if (n != int'(N_ISSUED)) begin n_err++; $display("FAIL table_count: got %0d want %0d", n, N_ISSUED); end
        for (int i = 0; i < int'(N_ISSUED); i++) begin
            n_cmp++;
            if (i >= n || got[i] !== EXP_TAB[i]) begin
                n_err++; $display("FAIL table_entry%0d: got %h want %h", i, (i < n) ? got[i] : 16'hxxxx, EXP_TAB[i]);
            end
        end
        n_cmp++; if (config_done !== 1'b1) begin n_err++; $display("FAIL table_done: got %b want 1", config_done); end
        n_cmp++; if (send !== 1'b0)        begin n_err++; $display("FAIL table_send_after_end: got %b want 0", send); end
    endtask

    task automatic test_done_taken_resend();
        taken = 1'b1; tick(); taken = 1'b0;
        repeat (3) tick();
        n_cmp++; if (config_done !== 1'b1 || send !== 1'b0) begin n_err++; $display("FAIL done_spurious_taken: done %b send %b want 1/0", config_done, send); end
        resend = 1'b1; taken = 1'b1; tick(); resend = 1'b0; taken = 1'b0;
        n_cmp++; if (config_done !== 1'b0) begin n_err++; $display("FAIL resend_clears_done: got %b want 0", config_done); end
        repeat (2) tick();
        n_cmp++; if (send !== 1'b1 || rega !== 8'h12 || value !== 8'h80) begin
            n_err++; $display("FAIL resend_taken_restart: send %b data %h%h want 1/1280", send, rega, value);
        end
    endtask

    task automatic test_resend_in_hold();
        bit ok;
        serve_until(8'h3E, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL reach_entry5: send %b rega %h want 1/3e", send, rega); end
        taken = 1'b1; tick(); taken = 1'b0;
        repeat (20) tick();
        resend = 1'b1; tick(); resend = 1'b0;
        n_cmp++; if (config_done !== 1'b0) begin n_err++; $display("FAIL hold_resend_done: got %b want 0", config_done); end
        repeat (2) tick();
        n_cmp++; if (send !== 1'b1 || rega !== 8'h12 || value !== 8'h80 || config_done !== 1'b0) begin
            n_err++; $display("FAIL hold_resend_entry0: send %b data %h%h done %b want 1/1280/0", send, rega, value, config_done);
        end
    endtask

    task automatic test_clr_in_issue();
        bit ok;
        int k;
        serve_until(8'h11, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL reach_entry3: send %b rega %h want 1/11", send, rega); end
        clr = 1'b1; tick(); clr = 1'b0;
        n_cmp++; if (send !== 1'b0 || rega !== 8'h00 || value !== 8'h00 || config_done !== 1'b0 || id !== 8'h42) begin
            n_err++; $display("FAIL clr_outputs: send %b data %h%h done %b id %h want 0/0000/0/42", send, rega, value, config_done, id);
        end
        k = 0;
        while (send !== 1'b1 && k < int'(PWR + 50)) begin tick(); k++; end
        n_cmp++; if (k != int'(FIRST_SEND)) begin n_err++; $display("FAIL clr_restart_latency: got %0d want %0d", k, FIRST_SEND); end
        n_cmp++; if (rega !== 8'h12 || value !== 8'h80) begin n_err++; $display("FAIL clr_restart_entry: got %h%h want 1280", rega, value); end
    endtask

    initial begin
        clk = 1'b0; clr = 1'b1; resend = 1'b0; taken = 1'b0;
        n_cmp = 0; n_err = 0; cycles = 0;
        test_reset();
        test_hold_delay();
        test_full_table();
        test_done_taken_resend();
        test_resend_in_hold();
        test_clr_in_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
